// File: rtl/stopwatch_segment_renderer.sv
// Stopwatch overlay renderer: snapshots H:MM:SS.mmm on frame_start, converts
// to BCD with a 10-cycle double-dabble, and answers per-pixel "is this pixel
// part of a lit segment" queries through a 2-stage pipeline.

// One digit cell: decides whether (x,y) lands on a lit segment of digit K.
module stopwatch_digit_cell #(
  parameter int DIGIT_WIDTH = 40,
  parameter int DIGIT_GAP   = 40,
  parameter int ORIGIN_X    = 0,
  parameter int ORIGIN_Y    = 200,
  parameter int K           = 0
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [3:0] code,
  output logic       hit
);
  localparam int T_I = (DIGIT_WIDTH / 10 > 1) ? DIGIT_WIDTH / 10 : 1;
  localparam int H_I = 2 * DIGIT_WIDTH;
  localparam logic [31:0] W_U  = 32'(DIGIT_WIDTH);
  localparam logic [31:0] H_U  = 32'(H_I);
  localparam logic [31:0] HH_U = 32'(H_I / 2);
  localparam logic [31:0] T_U  = 32'(T_I);
  localparam logic [31:0] G_U  = 32'(H_I * 45 / 100);
  localparam logic [31:0] X0   = 32'(ORIGIN_X + K * (DIGIT_WIDTH + DIGIT_GAP));
  localparam logic [31:0] Y0   = 32'(ORIGIN_Y);

  logic [31:0] px, py, u, v;
  logic        in_cell, top, bot, lcol, rcol;
  logic [6:0]  segs;  // {a,b,c,d,e,f,g}

  assign px      = {22'd0, x};
  assign py      = {22'd0, y};
  assign u       = px - X0;
  assign v       = py - Y0;
  assign in_cell = (px >= X0) && (px < X0 + W_U) && (py >= Y0) && (py < Y0 + H_U);
  assign top     = v < HH_U;
  assign bot     = !top;
  assign lcol    = u < T_U;
  assign rcol    = u >= W_U - T_U;

  // Standard seven-segment patterns; codes above 9 render blank.
  always_comb begin
    segs = 7'b0000000;
    case (code)
      4'd0: segs = 7'b1111110;
      4'd1: segs = 7'b0110000;
      4'd2: segs = 7'b1101101;
      4'd3: segs = 7'b1111001;
      4'd4: segs = 7'b0110011;
      4'd5: segs = 7'b1011011;
      4'd6: segs = 7'b1011111;
      4'd7: segs = 7'b1110000;
      4'd8: segs = 7'b1111111;
      4'd9: segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
  end

  assign hit = in_cell & (
      (segs[6] & (v < T_U))
    | (segs[5] & rcol & top)
    | (segs[4] & rcol & bot)
    | (segs[3] & (v >= H_U - T_U))
    | (segs[2] & lcol & bot)
    | (segs[1] & lcol & top)
    | (segs[0] & (v >= G_U) & (v < G_U + T_U)));
endmodule

module stopwatch_segment_renderer #(
  parameter int   SCREEN_WIDTH  = 640,
  parameter int   SCREEN_HEIGHT = 480,
  parameter int   DIGIT_WIDTH   = 40,
  parameter int   DIGIT_GAP     = 40,
  parameter int   ORIGIN_X      = 0,
  parameter int   ORIGIN_Y      = 200,
  parameter logic ON            = 1'b1,
  parameter logic OFF           = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [9:0] milliseconds,
  input  logic       frame_start,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       pixel_valid,
  output logic       pixel_on,
  output logic       pixel_out_valid,
  output logic       busy
);
  localparam int NUM_DIGITS = 8;
  localparam int STAGES     = 2;
  localparam logic [31:0] SW_U = 32'(SCREEN_WIDTH);
  localparam logic [31:0] SH_U = 32'(SCREEN_HEIGHT);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                         state;
  logic [3:0]                     cnt;
  logic [3:0]                     hrs_snap;
  logic [17:0]                    sh_m, sh_s;   // {bcd[7:0], bin[9:0]}
  logic [21:0]                    sh_ms;        // {bcd[11:0], bin[9:0]}
  logic [17:0]                    m_nxt, s_nxt;
  logic [21:0]                    ms_nxt;
  logic [9:0]                     ms_clamped;
  logic [NUM_DIGITS-1:0][3:0]     disp;

  logic [STAGES:1]                vld_pipe;
  logic [9:0]                     x1, y1;
  logic [NUM_DIGITS-1:0]          hit;
  logic                           visible;

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [17:0] dd2(input logic [17:0] s);
    logic [17:0] t;
    t = s;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[17:14] >= 4'd5) t[17:14] = t[17:14] + 4'd3;
    t = t << 1;
    return t;
  endfunction

  function automatic logic [21:0] dd3(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[17:14] >= 4'd5) t[17:14] = t[17:14] + 4'd3;
    if (t[21:18] >= 4'd5) t[21:18] = t[21:18] + 4'd3;
    t = t << 1;
    return t;
  endfunction

  assign ms_clamped = (milliseconds > 10'd999) ? 10'd999 : milliseconds;
  assign m_nxt      = dd2(sh_m);
  assign s_nxt      = dd2(sh_s);
  assign ms_nxt     = dd3(sh_ms);

  // Conversion FSM: frame_start always (re)starts; display commits on the 10th shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      hrs_snap <= '0;
      sh_m     <= '0;
      sh_s     <= '0;
      sh_ms    <= '0;
      disp     <= '0;
    end else if (frame_start) begin
      state    <= CONVERT;
      busy     <= 1'b1;
      cnt      <= '0;
      hrs_snap <= hours;
      sh_m     <= {12'd0, minutes};
      sh_s     <= {12'd0, seconds};
      sh_ms    <= {12'd0, ms_clamped};
    end else if (state == CONVERT) begin
      sh_m  <= m_nxt;
      sh_s  <= s_nxt;
      sh_ms <= ms_nxt;
      if (cnt == 4'd9) begin
        state   <= IDLE;
        busy    <= 1'b0;
        cnt     <= '0;
        disp[0] <= (hrs_snap < 4'd10) ? hrs_snap : 4'hF;
        disp[1] <= m_nxt[17:14];
        disp[2] <= m_nxt[13:10];
        disp[3] <= s_nxt[17:14];
        disp[4] <= s_nxt[13:10];
        disp[5] <= ms_nxt[21:18];
        disp[6] <= ms_nxt[17:14];
        disp[7] <= ms_nxt[13:10];
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    stopwatch_digit_cell #(
      .DIGIT_WIDTH(DIGIT_WIDTH), .DIGIT_GAP(DIGIT_GAP),
      .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .K(k)
    ) u_cell (
      .x(x1), .y(y1), .code(disp[k]), .hit(hit[k])
    );
  end

  assign visible = ({22'd0, x1} < SW_U) && ({22'd0, y1} < SH_U);

  // Pixel pipeline: stage 1 registers the scan position, stage 2 the lit decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      x1       <= '0;
      y1       <= '0;
      pixel_on <= OFF;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pixel_valid};
      x1       <= pixel_x;
      y1       <= pixel_y;
      pixel_on <= (vld_pipe[1] && visible && |hit) ? ON : OFF;
    end
  end

  assign pixel_out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_stopwatch_segment_renderer.sv
// Directed bench for the stopwatch renderer at default parameters
// (T=4, H=80, g rows 236..239, digit k at x=80k..80k+39, y=200..279).
module tb_stopwatch_segment_renderer;
  logic       clk, reset;
  logic [3:0] hours;
  logic [5:0] minutes, seconds;
  logic [9:0] milliseconds;
  logic       frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic       pixel_valid;
  logic       pixel_on, pixel_out_valid, busy;
  int         checks = 0;
  int         errors = 0;

  stopwatch_segment_renderer dut (
    .clk(clk), .reset(reset), .hours(hours), .minutes(minutes),
    .seconds(seconds), .milliseconds(milliseconds), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_on(pixel_on), .pixel_out_valid(pixel_out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and return the outputs two edges later.
  task automatic probe(input int x, input int y, input logic v,
                       output logic on, output logic ov);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    pixel_valid = v;
    tick();
    pixel_valid = 1'b0;
    tick();
    on = pixel_on;
    ov = pixel_out_valid;
  endtask

  task automatic pulse_frame(input int h, input int m, input int s, input int ms);
    hours = 4'(h);
    minutes = 6'(m);
    seconds = 6'(s);
    milliseconds = 10'(ms);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Counts sampled busy cycles; bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic on, ov;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (pixel_out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", pixel_out_valid); end
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL reset_on got %b exp 0", pixel_on); end
    reset = 1'b0;
    tick();
    // latency: valid must not appear after only one edge
    pixel_x = 10'd20; pixel_y = 10'd201; pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    checks++; if (pixel_out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b exp 0", pixel_out_valid); end
    tick();
    checks++; if (pixel_out_valid !== 1'b1) begin errors++; $display("FAIL latency_ov got %b exp 1", pixel_out_valid); end
    checks++; if (pixel_on !== 1'b1) begin errors++; $display("FAIL reset_seg_a got %b exp 1", pixel_on); end
    tick();
    checks++; if (pixel_out_valid !== 1'b0) begin errors++; $display("FAIL ov_single got %b exp 0", pixel_out_valid); end
    probe(20, 237, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL reset_seg_g got %b exp 0", on); end
  endtask

  task automatic test_hours();
    logic on, ov;
    int n;
    pulse_frame(8, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hours_busy_rise got %b exp 1", busy); end
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL hours_busy_len got %0d exp 10", n); end
    probe(20, 237, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL hours8_g got %b exp 1", on); end
  endtask

  task automatic test_ms_clamp();
    logic on, ov;
    int n;
    pulse_frame(8, 0, 0, 1023);
    wait_idle(n);
    probe(580, 237, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL ms_m0_g got %b exp 1", on); end
    // segment e is not part of a 9
    probe(561, 260, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL ms_m0_e got %b exp 0", on); end
    probe(598, 260, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL ms_m0_c got %b exp 1", on); end
    probe(420, 201, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL ms_m2_a got %b exp 1", on); end
  endtask

  task automatic test_hours_blank();
    logic on, ov;
    int n;
    pulse_frame(12, 0, 0, 0);
    wait_idle(n);
    probe(20, 201, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL blank_a got %b exp 0", on); end
    probe(38, 210, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL blank_b got %b exp 0", on); end
  endtask

  task automatic test_atomic();
    logic on, ov;
    int n;
    pulse_frame(1, 0, 0, 0);
    probe(38, 210, 1'b1, on, ov);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL atomic_busy got %b exp 1", busy); end
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL atomic_mid got %b exp 0", on); end
    wait_idle(n);
    probe(38, 210, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL atomic_done got %b exp 1", on); end
  endtask

  task automatic test_back_to_back();
    logic on, ov;
    int n;
    pulse_frame(0, 0, 11, 0);
    tick();
    tick();
    pulse_frame(0, 0, 40, 0);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_busy_len got %0d exp 10", n); end
    probe(241, 210, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL b2b_s1_f got %b exp 1", on); end
    probe(260, 201, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL b2b_s1_a got %b exp 0", on); end
    probe(321, 237, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL b2b_s0_f got %b exp 1", on); end
    probe(340, 237, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL b2b_s0_g got %b exp 0", on); end
  endtask

  task automatic test_off_cases();
    logic on, ov;
    probe(60, 220, 1'b1, on, ov);
    checks++; if (on !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL gap got on=%b ov=%b exp on=0 ov=1", on, ov); end
    probe(20, 100, 1'b1, on, ov);
    checks++; if (on !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL offband got on=%b ov=%b exp on=0 ov=1", on, ov); end
    probe(20, 201, 1'b0, on, ov);
    checks++; if (on !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL invalid got on=%b ov=%b exp on=0 ov=0", on, ov); end
  endtask

  task automatic test_reset_mid();
    logic on, ov;
    pulse_frame(8, 0, 0, 0);
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    tick();
    reset = 1'b0;
    repeat (12) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got %b exp 0", busy); end
    probe(20, 237, 1'b1, on, ov);
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL midreset_g got %b exp 0", on); end
    probe(20, 201, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL midreset_a got %b exp 1", on); end
    probe(260, 201, 1'b1, on, ov);
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL midreset_s1_a got %b exp 1", on); end
  endtask

  initial begin
    reset = 1'b1;
    hours = '0; minutes = '0; seconds = '0; milliseconds = '0;
    frame_start = 1'b0;
    pixel_x = '0; pixel_y = '0; pixel_valid = 1'b0;
    test_reset();
    test_hours();
    test_ms_clamp();
    test_hours_blank();
    test_atomic();
    test_back_to_back();
    test_off_cases();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
